// File: rtl/stage_phase_accumulator.sv
// rtl/stage_phase_accumulator.sv - per-slot phase accumulator stage feeding the waveform generator
//
// Holds one phase accumulator and one phase step per voice operator slot in on-chip RAM.
// Each cycle it advances the accumulator of the presented slot and adds its phase modulation.
//
// Ports:
//   i_Clock, i_Reset_n              clock (posedge) and asynchronous active-low reset
//   i_VoiceOperator, i_AlgorithmWord slot ID and pass-through algorithm word
//   i_PhaseModulation, i_PhaseReset modulation from upstream operator, key-sync zeroing
//   i_ConfigWriteEnable/Address/Data phase step writes (accepted once o_Ready is high)
//   o_Ready                         RAM clear finished
//   o_VoiceOperator, o_AlgorithmWord inputs delayed 3 cycles
//   o_Phase                         17-bit phase word, aligned with the delayed ID
module stage_phase_accumulator #(
    parameter int NUM_VOICE_OPERATORS = 64,
    parameter int ACC_WIDTH           = 32,
    parameter int ALG_WIDTH           = 8,
    localparam int ID_WIDTH           = $clog2(NUM_VOICE_OPERATORS)
) (
    input  logic                        i_Clock,
    input  logic                        i_Reset_n,
    input  logic [ID_WIDTH-1:0]         i_VoiceOperator,
    input  logic [ALG_WIDTH-1:0]        i_AlgorithmWord,
    input  logic signed [15:0]          i_PhaseModulation,
    input  logic                        i_PhaseReset,
    input  logic                        i_ConfigWriteEnable,
    input  logic [ID_WIDTH-1:0]         i_ConfigAddress,
    input  logic [ACC_WIDTH-1:0]        i_ConfigData,
    output logic                        o_Ready,
    output logic [ID_WIDTH-1:0]         o_VoiceOperator,
    output logic [ALG_WIDTH-1:0]        o_AlgorithmWord,
    output logic signed [16:0]          o_Phase
);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                  ready_q, ready_d;
    logic                  clearing;

    logic [ACC_WIDTH-1:0]  phase_ram [NUM_VOICE_OPERATORS];
    logic [ACC_WIDTH-1:0]  step_ram  [NUM_VOICE_OPERATORS];

    // Stage 1: RAM read data and captured slot fields
    logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
    logic [ALG_WIDTH-1:0]  s1_alg_q, s1_alg_d;
    logic [15:0]           s1_mod_q, s1_mod_d;
    logic                  s1_prst_q, s1_prst_d;
    logic                  s1_run_q, s1_run_d;
    logic [ACC_WIDTH-1:0]  s1_phase_q, s1_phase_d;
    logic [ACC_WIDTH-1:0]  s1_step_q, s1_step_d;

    // Stage 2: advanced accumulator (top 16 bits only travel on)
    logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;
    logic [ALG_WIDTH-1:0]  s2_alg_q, s2_alg_d;
    logic [15:0]           s2_mod_q, s2_mod_d;
    logic [15:0]           s2_hi_q, s2_hi_d;
    logic                  s2_run_q, s2_run_d;

    // Stage 3: output registers
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
    logic [ALG_WIDTH-1:0]  out_alg_q, out_alg_d;
    logic [16:0]           out_phase_q, out_phase_d;

    logic [ACC_WIDTH-1:0]  acc_next;
    logic                  phase_we, step_we;
    logic [ID_WIDTH-1:0]   phase_waddr, step_waddr;
    logic [ACC_WIDTH-1:0]  phase_wdata, step_wdata;

    // FSM state register
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // FSM next state: CLEAR walks every address once, RUN is terminal until reset
    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && clr_cnt_q == ID_WIDTH'(NUM_VOICE_OPERATORS - 1))
            state_d = ST_RUN;
    end

    // FSM outputs
    always_comb begin
        clearing  = (state_q == ST_CLEAR);
        clr_cnt_d = clearing ? clr_cnt_q + ID_WIDTH'(1) : clr_cnt_q;
        ready_d   = (state_d == ST_RUN);
    end

    // Write-back only for slots that were read after the clear finished; a slot read
    // during the last clear cycle may still see uncleared RAM and must not be stored.
    always_comb begin
        acc_next    = s1_prst_q ? '0 : s1_phase_q + s1_step_q;

        phase_we    = clearing | s1_run_q;
        phase_waddr = clearing ? clr_cnt_q : s1_id_q;
        phase_wdata = clearing ? '0 : acc_next;

        step_we     = clearing | i_ConfigWriteEnable;
        step_waddr  = clearing ? clr_cnt_q : i_ConfigAddress;
        step_wdata  = clearing ? '0 : i_ConfigData;
    end

    always_ff @(posedge i_Clock) begin
        if (phase_we)
            phase_ram[phase_waddr] <= phase_wdata;
        if (step_we)
            step_ram[step_waddr] <= step_wdata;
    end

    // Pipeline next-state; RAM reads see pre-edge contents, so a same-cycle step write
    // to the slot being read returns the old step.
    always_comb begin
        s1_id_d     = i_VoiceOperator;
        s1_alg_d    = i_AlgorithmWord;
        s1_mod_d    = i_PhaseModulation;
        s1_prst_d   = i_PhaseReset;
        s1_run_d    = ~clearing;
        s1_phase_d  = phase_ram[i_VoiceOperator];
        s1_step_d   = step_ram[i_VoiceOperator];

        s2_id_d     = s1_id_q;
        s2_alg_d    = s1_alg_q;
        s2_mod_d    = s1_mod_q;
        s2_hi_d     = acc_next[ACC_WIDTH-1 -: 16];
        s2_run_d    = s1_run_q;

        out_id_d    = s2_id_q;
        out_alg_d   = s2_alg_q;
        out_phase_d = s2_run_q ? ({1'b0, s2_hi_q} + {s2_mod_q[15], s2_mod_q}) : '0;
    end

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            s1_id_q     <= '0;
            s1_alg_q    <= '0;
            s1_mod_q    <= '0;
            s1_prst_q   <= 1'b0;
            s1_run_q    <= 1'b0;
            s1_phase_q  <= '0;
            s1_step_q   <= '0;
            s2_id_q     <= '0;
            s2_alg_q    <= '0;
            s2_mod_q    <= '0;
            s2_hi_q     <= '0;
            s2_run_q    <= 1'b0;
            out_id_q    <= '0;
            out_alg_q   <= '0;
            out_phase_q <= '0;
        end else begin
            s1_id_q     <= s1_id_d;
            s1_alg_q    <= s1_alg_d;
            s1_mod_q    <= s1_mod_d;
            s1_prst_q   <= s1_prst_d;
            s1_run_q    <= s1_run_d;
            s1_phase_q  <= s1_phase_d;
            s1_step_q   <= s1_step_d;
            s2_id_q     <= s2_id_d;
            s2_alg_q    <= s2_alg_d;
            s2_mod_q    <= s2_mod_d;
            s2_hi_q     <= s2_hi_d;
            s2_run_q    <= s2_run_d;
            out_id_q    <= out_id_d;
            out_alg_q   <= out_alg_d;
            out_phase_q <= out_phase_d;
        end
    end

    assign o_Ready         = ready_q;
    assign o_VoiceOperator = out_id_q;
    assign o_AlgorithmWord = out_alg_q;
    assign o_Phase         = out_phase_q;

endmodule
